// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter definitions: FSM states, fixed AR attributes, default IDs.
package axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR_I,
        S_AR_D,
        S_R_I,
        S_R_D
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'h0;
    localparam logic [2:0] AXI_PROT_NONE   = 3'h0;

    localparam logic [3:0] ID_I_DEFAULT = 4'h0;
    localparam logic [3:0] ID_D_DEFAULT = 4'h1;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Two-master (icache/dcache) AXI read arbiter, one outstanding burst, alternating
// priority on contention, sticky rd_err on any read-protocol violation.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter logic [3:0] ID_I = ID_I_DEFAULT,
    parameter logic [3:0] ID_D = ID_D_DEFAULT
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        rd_err
);

    state_t      state;
    logic        last_d;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [3:0]  id_q;
    logic [8:0]  beat_cnt;
    logic        arvalid_q;
    logic        err_q;

    logic pick_d;
    logic beat;
    logic final_cnt;

    // On contention, D wins unless D was the most recent grant.
    assign pick_d    = d_arvalid && (!i_arvalid || !last_d);
    assign beat      = rvalid && rready;
    assign final_cnt = (beat_cnt == {1'b0, len_q});

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            last_d    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            id_q      <= '0;
            beat_cnt  <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_arvalid || d_arvalid) begin
                        state     <= pick_d ? S_AR_D : S_AR_I;
                        last_d    <= pick_d;
                        addr_q    <= pick_d ? d_araddr : i_araddr;
                        len_q     <= pick_d ? d_arlen  : i_arlen;
                        size_q    <= pick_d ? d_arsize : i_arsize;
                        id_q      <= pick_d ? ID_D     : ID_I;
                        beat_cnt  <= '0;
                        arvalid_q <= 1'b1;
                    end
                end
                S_AR_I, S_AR_D: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        state     <= (state == S_AR_I) ? S_R_I : S_R_D;
                    end
                end
                S_R_I, S_R_D: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (rid != id_q || rresp != 2'b00)
                            err_q <= 1'b1;
                        // Burst ends on rlast or on the expected final beat; both must coincide.
                        if (rlast || final_cnt) begin
                            state <= S_IDLE;
                            if (!(rlast && final_cnt))
                                err_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;
    assign arvalid = arvalid_q;
    assign rd_err  = err_q;

    // Handshake signals pass through so ready/valid land in the same cycle as the AXI beat.
    assign i_arready = (state == S_AR_I) && arready;
    assign d_arready = (state == S_AR_D) && arready;

    assign i_rvalid = (state == S_R_I) && rvalid;
    assign d_rvalid = (state == S_R_D) && rvalid;
    assign i_rdata  = (state == S_R_I) ? rdata : '0;
    assign d_rdata  = (state == S_R_D) ? rdata : '0;
    assign i_rlast  = (state == S_R_I) && rlast;
    assign d_rlast  = (state == S_R_D) && rlast;

    always_comb begin
        rready = 1'b0;
        if (state == S_R_I)
            rready = i_rready;
        else if (state == S_R_D)
            rready = d_rready;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench: directed scenario table, hand-written corner sequences and
// randomized scenarios against a transaction-level grant/error model.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
    import axi_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] i_araddr, d_araddr;
    logic [7:0]  i_arlen, d_arlen;
    logic [2:0]  i_arsize, d_arsize;
    logic        i_arvalid, d_arvalid, i_arready, d_arready;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rlast, d_rlast, i_rvalid, d_rvalid, i_rready, d_rready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, rd_err;

    axi_rd_arbiter #(.ID_I(4'h0), .ID_D(4'h1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    bit raise_i_on_last = 1'b0;

    typedef struct {
        bit        rst_before;
        bit        ri;
        bit        rd;
        logic [7:0] li;
        logic [7:0] ld;
        int        dly;
        int        ekind;   // 0 none, 1 rresp, 2 rid, 3 rlast on beat 2, 4 rlast missing
        bit        exp_first_d;
        bit        exp_err;
    } vec_t;

    vec_t vecs[9];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("reset_outputs",
            {arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, rd_err}, 64'd0);
        chk("reset_state_idle", 64'(dut.state == S_IDLE), 64'd1);
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic serve(input bit is_d, input int dly, input int ekind, input bit exp_err);
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [31:0] dat;
        logic        lst;
        int nb;
        id   = is_d ? 4'h1 : 4'h0;
        addr = is_d ? d_araddr : i_araddr;
        len  = is_d ? d_arlen : i_arlen;
        size = is_d ? d_arsize : i_arsize;

        #1;
        chk("idle_no_arvalid", arvalid, 0);
        tick();
        chk("ar_valid", arvalid, 1);
        chk("ar_id", arid, id);
        chk("ar_addr", araddr, addr);
        chk("ar_len", arlen, len);
        chk("ar_size", arsize, size);
        chk("ar_attr", {arburst, arlock, arcache, arprot}, {2'b01, 9'd0});
        // requester withdraws right after grant; latched request must still complete
        if (is_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
        for (int k = 0; k < dly; k++) begin
            #1;
            chk("ar_wait_no_ready", is_d ? d_arready : i_arready, 0);
            tick();
            chk("ar_hold", {arvalid, arid, araddr, arlen}, {1'b1, id, addr, len});
        end
        arready = 1'b1;
        #1;
        chk("ar_ready_pulse", is_d ? d_arready : i_arready, 1);
        chk("ar_other_ready", is_d ? i_arready : d_arready, 0);
        tick();
        arready = 1'b0;
        #1;
        chk("ar_ready_single", {i_arready, d_arready, arvalid}, 0);

        nb = (ekind == 3) ? 2 : int'(len) + 1;
        for (int b = 0; b < nb; b++) begin
            dat    = $urandom;
            lst    = (ekind == 4) ? 1'b0 : (b == nb - 1);
            rvalid = 1'b1;
            rdata  = dat;
            rid    = (ekind == 2 && b == 0) ? ~id : id;
            rresp  = (ekind == 1 && b == 0) ? 2'b10 : 2'b00;
            rlast  = lst;
            if ($urandom_range(0, 3) == 0) begin
                if (is_d) d_rready = 1'b0; else i_rready = 1'b0;
                #1;
                chk("stall_rready", rready, 0);
                chk("stall_rvalid", is_d ? d_rvalid : i_rvalid, 1);
                tick();
                if (is_d) d_rready = 1'b1; else i_rready = 1'b1;
            end
            if (raise_i_on_last && b == nb - 1) i_arvalid = 1'b1;
            #1;
            chk("beat_rvalid", is_d ? d_rvalid : i_rvalid, 1);
            chk("beat_other_rvalid", is_d ? i_rvalid : d_rvalid, 0);
            chk("beat_rdata", is_d ? d_rdata : i_rdata, dat);
            chk("beat_rlast", is_d ? d_rlast : i_rlast, lst);
            chk("beat_rready", rready, 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rid    = 4'h0;
        chk("burst_end_idle", 64'(dut.state == S_IDLE), 64'd1);
        chk("burst_rd_err", rd_err, exp_err);
        chk("idle_no_rvalid", {i_rvalid, d_rvalid}, 0);
    endtask

    task automatic scenario(input bit ri, input bit rd, input logic [7:0] li, input logic [7:0] ld,
                            input logic [31:0] ai, input logic [31:0] ad, input int dly,
                            input int ekind, input bit first_d, input bit exp_err);
        i_araddr = ai; i_arlen = li; i_arsize = 3'd2;
        d_araddr = ad; d_arlen = ld; d_arsize = 3'd3;
        i_arvalid = ri;
        d_arvalid = rd;
        if (ri && rd) begin
            serve(first_d, dly, ekind, exp_err);
            serve(!first_d, dly, 0, exp_err);
        end else begin
            serve(rd, dly, ekind, exp_err);
        end
        tick();
        chk("no_extra_ar", arvalid, 0);
    endtask

    bit m_last_d;
    bit m_err;

    initial begin
        aresetn = 1'b0;
        i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 1'b0; i_rready = 1'b1;
        d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b1;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

        //          rst  ri  rd  li     ld     dly ek first_d err
        vecs[0] = '{1'b0, 1, 1, 8'd1, 8'd3, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 0, 1, 8'd0, 8'd3, 1, 0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1, 1, 8'd2, 8'd0, 5, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1, 0, 8'd0, 8'd0, 0, 1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 0, 1, 8'd0, 8'd3, 1, 3, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1, 1, 8'd1, 8'd1, 2, 0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1, 0, 8'd2, 8'd0, 0, 2, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 0, 1, 8'd0, 8'd0, 0, 4, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1, 1, 8'd3, 8'd2, 1, 0, 1'b0, 1'b1};

        #2;
        do_reset();
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].rst_before) do_reset();
            scenario(vecs[v].ri, vecs[v].rd, vecs[v].li, vecs[v].ld,
                     32'h0000_1000 + 32'(v) * 32'h40, 32'h1FC0_0000 + 32'(v) * 32'h80,
                     vecs[v].dly, vecs[v].ekind, vecs[v].exp_first_d, vecs[v].exp_err);
        end

        // new I request raised on the final D beat is served only after an idle cycle
        do_reset();
        i_araddr = 32'h0000_2000; i_arlen = 8'd1; i_arsize = 3'd2;
        d_araddr = 32'h1FC0_0100; d_arlen = 8'd2; d_arsize = 3'd2;
        d_arvalid = 1'b1;
        raise_i_on_last = 1'b1;
        serve(1'b1, 0, 0, 1'b0);
        raise_i_on_last = 1'b0;
        serve(1'b0, 0, 0, 1'b0);
        tick();
        chk("late_no_extra_ar", arvalid, 0);

        // reset during the second beat of a D burst
        d_araddr = 32'h1FC0_0200; d_arlen = 8'd3; d_arsize = 3'd2;
        d_arvalid = 1'b1;
        tick();
        d_arvalid = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hA5A5_0001; rid = 4'h1; rlast = 1'b0;
        #1;
        chk("rst_seq_beat0", d_rvalid, 1);
        tick();
        rdata = 32'hA5A5_0002;
        aresetn = 1'b0;
        #1;
        chk("midburst_reset_outputs",
            {arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, rd_err}, 64'd0);
        chk("midburst_reset_idle", 64'(dut.state == S_IDLE), 64'd1);
        tick();
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("after_reset_no_rvalid", {d_rvalid, i_rvalid, rready}, 0);
        end
        rvalid = 1'b0;
        rdata = '0;

        // randomized scenarios against the transaction-level model
        do_reset();
        m_last_d = 1'b0;
        m_err = 1'b0;
        for (int n = 0; n < 40; n++) begin
            bit ri, rd, first_d;
            int sel, ek, dly;
            logic [7:0] li, ld, flen;
            if ($urandom_range(0, 5) == 0) begin
                do_reset();
                m_last_d = 1'b0;
                m_err = 1'b0;
            end
            sel = $urandom_range(0, 2);
            ri = (sel != 1);
            rd = (sel != 0);
            li = 8'($urandom_range(0, 4));
            ld = 8'($urandom_range(0, 4));
            dly = $urandom_range(0, 3);
            ek = $urandom_range(0, 7);
            if (ek > 4) ek = 0;
            first_d = (ri && rd) ? !m_last_d : rd;
            flen = first_d ? ld : li;
            if (ek == 3 && flen < 8'd2) ek = 0;
            if (ek != 0) m_err = 1'b1;
            scenario(ri, rd, li, ld, $urandom, $urandom, dly, ek, first_d, m_err);
            m_last_d = (ri && rd) ? !first_d : rd;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
